// File: rtl/tsa_pkg.sv
// Shared types, widths and the round-robin pick helper for timer_share_arbiter.
package tsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tsa_state_t;

  localparam int unsigned TSA_SVC_W   = 16;
  localparam int unsigned TSA_MAX_REQ = 8;
  localparam int unsigned TSA_PTR_W   = 3;

  // One-hot of the first set request searching from ptr+1, wrapping at num_req.
  function automatic logic [TSA_MAX_REQ-1:0] rr_pick(
    input logic [TSA_MAX_REQ-1:0] req,
    input logic [TSA_PTR_W-1:0]   ptr,
    input int unsigned            num_req
  );
    logic [TSA_MAX_REQ-1:0] pick;
    logic                   found;
    logic [TSA_PTR_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= TSA_MAX_REQ; k++) begin
      if (k <= num_req) begin
        idx = TSA_PTR_W'((32'(ptr) + k) % num_req);
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tsa_interval_counter.sv
// Flex-style interval counter: counts 1..rollover_val then wraps to 1; clear wins over enable.
module tsa_interval_counter #(
  parameter int unsigned NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/timer_share_arbiter.sv
// Round-robin sharing of one interval counter among NUM_REQ requesters.
// Optional TSA_SERVICE_CNT_EN adds a saturating count of completed intervals.
module timer_share_arbiter
  import tsa_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_CNT_BITS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_period,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         count_out
`ifdef TSA_SERVICE_CNT_EN
  ,
  output logic [TSA_SVC_W-1:0]            serviced_cnt
`endif
);

  tsa_state_t              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    busy_q, busy_d;
  logic [TSA_PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CNT_BITS-1:0] period_q, period_d;

  logic [NUM_REQ-1:0]      pick_c;
  logic [TSA_PTR_W-1:0]    sel_idx_c;
  logic [NUM_CNT_BITS-1:0] sel_period_c;
  logic                    owner_req_c;
  logic                    cnt_clear_c;
  logic                    cnt_en_c;
  logic                    rollover_c;

  // Arbitration winner, its index and its requested period.
  always_comb begin
    pick_c       = NUM_REQ'(rr_pick(TSA_MAX_REQ'(req), rr_ptr_q, NUM_REQ));
    sel_idx_c    = '0;
    sel_period_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_c[i]) begin
        sel_idx_c    = TSA_PTR_W'(i);
        sel_period_c = req_period[i*NUM_CNT_BITS +: NUM_CNT_BITS];
      end
    end
  end

  assign owner_req_c = |(req & grant_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    rr_ptr_d    = rr_ptr_q;
    period_d    = period_q;
    cnt_clear_c = 1'b1;
    cnt_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d  = RUN;
          grant_d  = pick_c;
          rr_ptr_d = sel_idx_c;
          period_d = (sel_period_c == '0) ? NUM_CNT_BITS'(1) : sel_period_c;
        end
      end
      RUN: begin
        cnt_en_c    = 1'b1;
        cnt_clear_c = 1'b0;
        // A dropped owner request outranks a same-cycle rollover.
        if (!owner_req_c) begin
          state_d     = IDLE;
          grant_d     = '0;
          cnt_clear_c = 1'b1;
        end else if (rollover_c) begin
          state_d     = DONE;
          done_d      = grant_q;
          cnt_clear_c = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= TSA_PTR_W'(NUM_REQ - 1);
      period_q <= NUM_CNT_BITS'(1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      period_q <= period_d;
    end
  end

  tsa_interval_counter #(
    .NUM_CNT_BITS (NUM_CNT_BITS)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (cnt_clear_c),
    .count_enable  (cnt_en_c),
    .rollover_val  (period_q),
    .count_out     (count_out),
    .rollover_flag (rollover_c)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

`ifdef TSA_SERVICE_CNT_EN
  logic [TSA_SVC_W-1:0] svc_q, svc_d;

  // Saturating count of completed (non-aborted) intervals.
  always_comb begin
    svc_d = svc_q;
    if ((|done_d) && (svc_q != '1)) svc_d = svc_q + TSA_SVC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) svc_q <= '0;
    else     svc_q <= svc_d;
  end

  assign serviced_cnt = svc_q;
`endif

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Self-checking bench for timer_share_arbiter: directed table, corner sequences, random vs. timeline model.
module tb_timer_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_period;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count_out;
`ifdef TSA_SERVICE_CNT_EN
  logic [15:0]    serviced_cnt;
`endif

  timer_share_arbiter #(.NUM_REQ(N), .NUM_CNT_BITS(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_period (req_period),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .count_out  (count_out)
`ifdef TSA_SERVICE_CNT_EN
    ,
    .serviced_cnt (serviced_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // Timeline model: an owner granted at edge s shows count j at edge s+j (j=0..P),
  // done at s+P+1 and is idle at s+P+2; a dropped owner request before done aborts.
  int           m_owner = -1;
  int           m_s     = 0;
  int           m_p     = 1;
  int           m_ptr   = N - 1;
  int           m_k     = 0;
  int           m_svc   = 0;
  logic [N-1:0] e_grant, e_done;
  logic         e_busy;
  logic [W-1:0] e_count;

  task automatic model_update();
    int e;
    int idx;
    int per;
    e_grant = '0;
    e_done  = '0;
    e_busy  = 1'b0;
    e_count = '0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_svc   = 0;
    end else if (m_owner >= 0) begin
      e = m_k - m_s;
      if (e <= m_p + 1 && !req[m_owner]) begin
        m_owner = -1;
      end else if (e <= m_p) begin
        e_grant[m_owner] = 1'b1;
        e_busy  = 1'b1;
        e_count = W'(e);
      end else if (e == m_p + 1) begin
        e_grant[m_owner] = 1'b1;
        e_done[m_owner]  = 1'b1;
        e_busy  = 1'b1;
        if (m_svc < 65535) m_svc++;
      end else begin
        m_owner = -1;
      end
    end else if (req != '0) begin
      idx = -1;
      for (int j = 1; j <= N; j++) begin
        if (idx < 0 && req[(m_ptr + j) % N]) idx = (m_ptr + j) % N;
      end
      per     = int'(req_period[idx*W +: W]);
      m_owner = idx;
      m_s     = m_k;
      m_p     = (per == 0) ? 1 : per;
      m_ptr   = idx;
      e_grant[idx] = 1'b1;
      e_busy  = 1'b1;
    end
    m_k++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("count_out", 32'(count_out), 32'(e_count));
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    chk("done_onehot0", 32'($onehot0(done)), 32'd1);
`ifdef TSA_SERVICE_CNT_EN
    chk("serviced_cnt", 32'(serviced_cnt), 32'(m_svc));
`endif
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] count;
  } vec_t;

  vec_t         tbl[12];
  logic [N-1:0] exp_ord[5];
  logic [N-1:0] order[$];
  logic [N-1:0] prev_g;

  initial begin
    // rst, req -> grant, done, busy, count ; periods p0=3, p1=7, p2=0, p3=9
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'd1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'd2};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 8'd3};
    tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 8'd0};
    tbl[11] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd0};
    exp_ord[0] = 4'b0001;
    exp_ord[1] = 4'b0010;
    exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000;
    exp_ord[4] = 4'b0001;

    rst        = 1'b1;
    req        = '0;
    req_period = {8'd9, 8'd0, 8'd7, 8'd3};

    // Single interval of 3 then a zero period treated as 1.
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      step();
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_count", i), 32'(count_out), 32'(tbl[i].count));
    end

    // Rotation with all requesters held and period 1.
    rst = 1'b1; req = '0; req_period = {4{8'd1}};
    step();
    rst = 1'b0; req = 4'b1111; prev_g = '0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (grant != '0 && prev_g == '0) order.push_back(grant);
      prev_g = grant;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_order%0d", i), 32'((order.size() > i) ? order[i] : 4'b0000), 32'(exp_ord[i]));
    end

    // Owner drops its request at count 2 of 5.
    rst = 1'b1; req = '0; req_period = {8'd1, 8'd1, 8'd1, 8'd5};
    step();
    rst = 1'b0; req = 4'b0001;
    for (int i = 0; i < 12 && count_out != W'(2); i++) step();
    chk("abort_reach_cnt2", 32'(count_out), 32'd2);
    req = 4'b0000;
    step();
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_count", 32'(count_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Reset at count 4 of 8, then fresh arbitration starts at requester 0.
    req = 4'b0010; req_period = {8'd1, 8'd1, 8'd8, 8'd1};
    for (int i = 0; i < 12 && count_out != W'(4); i++) step();
    chk("rst_reach_cnt4", 32'(count_out), 32'd4);
    rst = 1'b1;
    step();
    chk("rst_outputs", 32'({grant, done, busy, count_out}), 32'd0);
    rst = 1'b0; req = 4'b1111;
    step();
    chk("rst_fresh_grant", 32'(grant), 32'b0001);

    // Random traffic checked against the model.
    rst = 1'b1; req = '0;
    step();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 64) == 0;
      for (int b = 0; b < N; b++) begin
        if ($urandom % 10 == 0) req[b] = ~req[b];
        req_period[b*W +: W] = W'($urandom_range(0, 6));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
